gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Sequential binary/Gray up/down counter that produces the 4-bit (parameterisable) code stream consumed by the binary-to-Gray conversion stage and by Gray-coded pointer logic.
- Holds a binary count register and a registered Gray copy derived from the *next* binary value, so both outputs update on the same clock edge.
- Gray output changes by exactly one bit per count step.
- Sits directly upstream of the code-conversion/display path in the conversions group.

Parameters:
- WIDTH, 4, counter width in bits (min 2).
- SATURATE, 0: 0 means the counter wraps modulo 2^WIDTH; 1 means it holds at the terminal value.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- en  input  1  count enable for the current cycle
- up  input  1  direction when en=1: 1 counts up, 0 counts down
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  binary value to load
- bin_q  output  WIDTH  registered binary count
- gray_q  output  WIDTH  registered Gray code of bin_q
- wrap  output  1  one-cycle pulse: a terminal-count step occurred on the previous edge
- at_term  output  1  combinational: bin_q is all-ones (up=1) or zero (up=0)

Behaviour:
- Reset (rst_n=0 at rising edge): bin_q=0, gray_q=0, wrap=0. Reset overrides load and en. A reset asserted mid-count takes effect on the next edge with no partial update.
- Priority per edge: rst_n low > load > en > hold.
- Load: bin_q<=load_val and gray_q<=G(load_val). wrap<=0. en is ignored that cycle. A load is not a count step, so gray_q may change in more than one bit.
- Count, en=1 and load=0:
  - up=1: next = bin_q+1.
  - up=0: next = bin_q-1.
  - Arithmetic is WIDTH bits; the carry/borrow is discarded.
- Terminal step is an up-step from 2^WIDTH-1 or a down-step from 0:
  - SATURATE=0: wraps to 0 or 2^WIDTH-1 respectively, and wrap<=1.
  - SATURATE=1: bin_q and gray_q hold, and wrap<=1 (the pulse flags the attempted overrun).
- Non-terminal step or hold: wrap<=0. wrap is never high for two consecutive cycles unless a terminal step is repeated (SATURATE=1 with en held, or wrap-mode alternation).
- Gray mapping G(b): g[WIDTH-1]=b[WIDTH-1]; g[i]=b[i]^b[i+1] for i<WIDTH-1.
- Invariant: gray_q==G(bin_q) in every cycle after reset.
- Latency: 1 clock from en/load sampled to bin_q/gray_q update. Both outputs update on the same edge; there is no skew between them.
- Hold (en=0, load=0): all registers keep their value, and wrap<=0.
- Direction may change on any cycle; the new direction applies to that cycle's step.
- at_term is purely combinational from bin_q and up and is not registered.

Decomposition:
- Shared package gray_pkg holds:
  - WIDTH default constant.
  - Function bin2gray(b), the G mapping above.
  - Function gray2bin(g), for benches: b[W-1]=g[W-1], b[i]=b[i+1]^g[i].
- No sub-module is needed. The Gray encoding is a package function applied to the next-state binary value. The existing combinational converter must not be instantiated, to keep gray_q registered.

Test Plan:
1. Reset then count up, WIDTH=4: rst_n=0 for 2 cycles, then en=1, up=1 for 16 cycles.
   - Required: bin_q 0,1,...,15,0 and gray_q 0000,0001,0011,0010,...,1000,0000.
   - Required: wrap pulses once, exactly 1 cycle after the 15->0 edge.
   - Required: every step's gray_q Hamming distance is 1.
2. Count down from 0 with SATURATE=0: en=1, up=0.
   - Required: bin_q 0->15->14, with wrap=1 only after the 0->15 edge.
   - Required: gray_q 0000->1000->1001.
3. Saturate with SATURATE=1: load 15, then en=1, up=1 for 3 cycles.
   - Required: bin_q stays 15 and gray_q stays 1000.
   - Required: wrap=1 on each of the 3 following cycles; at_term=1.
4. Load priority: bin_q=5, apply load=1, load_val=10 together with en=1, up=1.
   - Required: next bin_q=10 (not 6), gray_q=1111, wrap=0.
5. Mid-count reset: counting at bin_q=9, drive rst_n=0 for 1 cycle with en=1.
   - Required: the next edge gives bin_q=0, gray_q=0, wrap=0.
   - Required: counting resumes from 1 after rst_n returns to 1.
6. Hold and direction flip:
   - Stepping en 1,0,1 gives bin_q 3->4->4->5.
   - Then up=0 for 2 cycles gives 5->4->3.
   - Required: gray_q tracks G(bin_q) every cycle, checked with gray2bin.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants and binary/Gray conversion helpers
// for the Gray up/down counter and its benches.
package gray_pkg;

    localparam int GRAY_WIDTH = 4;
    localparam int GRAY_MAXW  = 32;

    typedef logic [GRAY_MAXW-1:0] gvec_t;

    // Zero-extended inputs keep the top output bit equal to b[W-1].
    function automatic gvec_t bin2gray(input gvec_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gvec_t gray2bin(input gvec_t g);
        gvec_t b;
        b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
        for (int i = GRAY_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter.sv
// Binary up/down counter with a registered Gray copy
// encoded from the next-state value, so both update together.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH    = GRAY_WIDTH,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             wrap,
    output logic             at_term
);

    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_d;

    assign at_term = up ? (&bin_q) : ~(|bin_q);

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_val;
        end else if (en) begin
            if (at_term) begin
                wrap_d = 1'b1;
                if (SATURATE == 0) begin
                    bin_d = up ? '0 : '1;
                end
            end else begin
                bin_d = up ? bin_q + 1'b1 : bin_q - 1'b1;
            end
        end
    end

    assign gray_d = WIDTH'(bin2gray(GRAY_MAXW'(bin_d)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap   <= wrap_d;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Directed vector bench for gray_counter in wrap and
// saturate configurations.
module tb_gray_counter;
    import gray_pkg::*;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] lv;
        logic [3:0] bin;
        logic [3:0] gray;
        logic       wrp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n, en, up, load;
    logic [3:0] load_val;
    logic [3:0] bin_w, gray_w, bin_s, gray_s;
    logic       wrap_w, wrap_s, at_w, at_s;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tv[$];

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4), .SATURATE(0)) u_w (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up),
        .load(load), .load_val(load_val),
        .bin_q(bin_w), .gray_q(gray_w),
        .wrap(wrap_w), .at_term(at_w)
    );

    gray_counter #(.WIDTH(4), .SATURATE(1)) u_s (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up),
        .load(load), .load_val(load_val),
        .bin_q(bin_s), .gray_q(gray_s),
        .wrap(wrap_s), .at_term(at_s)
    );

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic u,
                       input logic l, input logic [3:0] v,
                       input logic [3:0] b, input logic [3:0] g,
                       input logic w);
        vec_t x;
        x.rst_n = r; x.en = e; x.up = u; x.load = l; x.lv = v;
        x.bin = b; x.gray = g; x.wrp = w;
        tv.push_back(x);
    endtask

    task automatic drive(input logic r, input logic e, input logic u,
                         input logic l, input logic [3:0] v);
        rst_n = r; en = e; up = u; load = l; load_val = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] prev;
        logic       exp_at;
        // reset, then count up through the wrap
        add(0,0,1,0,0, 0, 4'b0000, 0);
        add(0,1,1,0,0, 0, 4'b0000, 0);
        add(1,1,1,0,0, 1, 4'b0001, 0);
        add(1,1,1,0,0, 2, 4'b0011, 0);
        add(1,1,1,0,0, 3, 4'b0010, 0);
        add(1,1,1,0,0, 4, 4'b0110, 0);
        add(1,1,1,0,0, 5, 4'b0111, 0);
        add(1,1,1,0,0, 6, 4'b0101, 0);
        add(1,1,1,0,0, 7, 4'b0100, 0);
        add(1,1,1,0,0, 8, 4'b1100, 0);
        add(1,1,1,0,0, 9, 4'b1101, 0);
        add(1,1,1,0,0,10, 4'b1111, 0);
        add(1,1,1,0,0,11, 4'b1110, 0);
        add(1,1,1,0,0,12, 4'b1010, 0);
        add(1,1,1,0,0,13, 4'b1011, 0);
        add(1,1,1,0,0,14, 4'b1001, 0);
        add(1,1,1,0,0,15, 4'b1000, 0);
        add(1,1,1,0,0, 0, 4'b0000, 1);
        // down from zero
        add(1,1,0,0,0,15, 4'b1000, 1);
        add(1,1,0,0,0,14, 4'b1001, 0);
        // load priority over count
        add(1,0,1,1,5, 5, 4'b0111, 0);
        add(1,1,1,1,10,10,4'b1111, 0);
        // mid-count reset
        add(1,0,1,1,9, 9, 4'b1101, 0);
        add(0,1,1,0,0, 0, 4'b0000, 0);
        add(1,1,1,0,0, 1, 4'b0001, 0);
        // hold and direction flip
        add(1,0,1,1,3, 3, 4'b0010, 0);
        add(1,1,1,0,0, 4, 4'b0110, 0);
        add(1,0,1,0,0, 4, 4'b0110, 0);
        add(1,1,1,0,0, 5, 4'b0111, 0);
        add(1,1,0,0,0, 4, 4'b0110, 0);
        add(1,1,0,0,0, 3, 4'b0010, 0);

        rst_n = 1'b0; en = 1'b0; up = 1'b1;
        load = 1'b0; load_val = '0;

        foreach (tv[i]) begin
            prev = gray_w;
            drive(tv[i].rst_n, tv[i].en, tv[i].up, tv[i].load, tv[i].lv);
            exp_at = tv[i].up ? (tv[i].bin == 4'hF) : (tv[i].bin == 4'h0);
            chk("bin", i, 32'(bin_w), 32'(tv[i].bin));
            chk("gray", i, 32'(gray_w), 32'(tv[i].gray));
            chk("wrap", i, 32'(wrap_w), 32'(tv[i].wrp));
            chk("at_term", i, 32'(at_w), 32'(exp_at));
            chk("g2b", i, gray2bin(32'(gray_w)), 32'(tv[i].bin));
            if (tv[i].rst_n && tv[i].en && !tv[i].load) begin
                chk("hamming", i, 32'($countones(prev ^ gray_w)), 32'd1);
            end
        end

        // saturate at the top, three attempted steps
        drive(1,0,1,1,15);
        chk("sat_load_bin", 0, 32'(bin_s), 32'd15);
        chk("sat_load_wrap", 0, 32'(wrap_s), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1,1,1,0,0);
            chk("sat_bin", k, 32'(bin_s), 32'd15);
            chk("sat_gray", k, 32'(gray_s), 32'b1000);
            chk("sat_wrap", k, 32'(wrap_s), 32'd1);
            chk("sat_at", k, 32'(at_s), 32'd1);
            chk("wrp_bin", k, 32'(bin_w), 32'(k));
        end
        chk("wrp_wrap", 0, 32'(wrap_w), 32'd0);

        // saturate at the bottom
        drive(1,0,0,1,0);
        chk("sat_lo_at", 0, 32'(at_s), 32'd1);
        drive(1,1,0,0,0);
        chk("sat_lo_bin", 0, 32'(bin_s), 32'd0);
        chk("sat_lo_wrap", 0, 32'(wrap_s), 32'd1);
        drive(1,0,0,0,0);
        chk("sat_lo_hold", 0, 32'(wrap_s), 32'd0);
        chk("sat_lo_bin2", 0, 32'(bin_s), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
